// File: rtl/apple_placer_pkg.sv
// apple_placer_pkg: grid geometry, coordinate type, placer state encoding and grid range helper
package apple_placer_pkg;
    localparam int GRID_W  = 30;
    localparam int GRID_H  = 20;
    localparam int COORD_W = 5;
    localparam int CELLS   = GRID_W * GRID_H;
    localparam int SCAN_W  = $clog2(CELLS + 1);
    typedef logic [COORD_W-1:0] coord_t;
    typedef enum logic [2:0] {IDLE, SAMPLE, CHECK, SCAN, SCAN_CHK, FULL} state_t;
    function automatic logic in_grid(input coord_t x, input coord_t y);
        return (x < coord_t'(GRID_W)) && (y < coord_t'(GRID_H));
    endfunction
endpackage

// File: rtl/apple_placer_if.sv
// apple_placer_if: eat request, random candidates, occupancy query/response and apple status
//   master: environment side (drives eat, rand_x/y, occ_hit)
//   slave:  placer side (drives occ_rd_*, apple_*, busy, grid_full)
interface apple_placer_if;
    import apple_placer_pkg::*;
    logic   eat;
    coord_t rand_x;
    coord_t rand_y;
    logic   occ_rd_en;
    coord_t occ_rd_x;
    coord_t occ_rd_y;
    logic   occ_hit;
    coord_t apple_x;
    coord_t apple_y;
    logic   apple_valid;
    logic   busy;
    logic   grid_full;
    modport master(output eat, rand_x, rand_y, occ_hit,
                   input occ_rd_en, occ_rd_x, occ_rd_y, apple_x, apple_y, apple_valid, busy, grid_full);
    modport slave(input eat, rand_x, rand_y, occ_hit,
                  output occ_rd_en, occ_rd_x, occ_rd_y, apple_x, apple_y, apple_valid, busy, grid_full);
endinterface

// File: rtl/apple_placer_grid_raster_step.sv
// grid_raster_step: next cell in raster order, x wraps into y+1, last row wraps to row 0
//   x, y   in   current cell
//   nx, ny out  successor cell
module grid_raster_step
    import apple_placer_pkg::*;
(
    input  coord_t x,
    input  coord_t y,
    output coord_t nx,
    output coord_t ny
);
    always_comb begin
        nx = (x == coord_t'(GRID_W - 1)) ? '0 : x + coord_t'(1);
        ny = (x != coord_t'(GRID_W - 1)) ? y : (y == coord_t'(GRID_H - 1)) ? '0 : y + coord_t'(1);
    end
endmodule

// File: rtl/apple_placer.sv
// apple_placer: picks a free grid cell for the next apple from random candidates, then raster fallback
//   clk, rst  clock and asynchronous active-high reset
//   bus       apple_placer_if.slave: eat/rand in, occupancy query out/hit in, apple position and status out
module apple_placer
    import apple_placer_pkg::*;
#(
    parameter int     MAX_TRIES = 16,
    parameter coord_t INIT_X    = coord_t'(2),
    parameter coord_t INIT_Y    = coord_t'(2)
) (
    input logic          clk,
    input logic          rst,
    apple_placer_if.slave bus
);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0]  TRY_MAX  = TRY_W'(MAX_TRIES);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(CELLS);
    state_t state, state_n;
    logic [TRY_W-1:0] try_cnt, try_n, base;
    logic [SCAN_W-1:0] scan_cnt, scan_n;
    coord_t cand_x, cand_y, cx_n, cy_n, step_x, step_y, start_x, start_y;
    coord_t qx_n, qy_n, ax_n, ay_n;
    logic en_n, av_n, busy_n, full_n, smp;
    grid_raster_step u_step (.x(cand_x), .y(cand_y), .nx(step_x), .ny(step_y));
    assign start_x = in_grid(cand_x, cand_y) ? step_x : '0;
    assign start_y = in_grid(cand_x, cand_y) ? step_y : '0;
    // A query is visible for one cycle and its hit arrives the next, so CHECK/SCAN_CHK
    // spend the query cycle waiting (occ_rd_en high) and judge occ_hit only once it drops.
    // Sampling a candidate is shared by IDLE (on eat), SAMPLE and a CHECK hit so an
    // occupied candidate costs two cycles and an out-of-range one costs one.
    always_comb begin
        state_n = state;
        try_n   = try_cnt;
        scan_n  = scan_cnt;
        cx_n    = cand_x;
        cy_n    = cand_y;
        en_n    = 1'b0;
        qx_n    = bus.occ_rd_x;
        qy_n    = bus.occ_rd_y;
        ax_n    = bus.apple_x;
        ay_n    = bus.apple_y;
        av_n    = bus.apple_valid;
        busy_n  = bus.busy;
        full_n  = bus.grid_full;
        smp     = 1'b0;
        base    = (state == CHECK) ? try_cnt + TRY_W'(1) : (state == IDLE) ? '0 : try_cnt;
        case (state)
            IDLE: begin
                if (bus.eat) begin
                    av_n   = 1'b0;
                    busy_n = 1'b1;
                    scan_n = '0;
                    smp    = 1'b1;
                end
            end
            SAMPLE: smp = 1'b1;
            CHECK: begin
                if (!bus.occ_rd_en) begin
                    if (!bus.occ_hit) begin
                        ax_n    = cand_x;
                        ay_n    = cand_y;
                        av_n    = 1'b1;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end else if (base == TRY_MAX) begin
                        try_n   = base;
                        state_n = SCAN;
                    end else begin
                        smp = 1'b1;
                    end
                end
            end
            SCAN: begin
                cx_n    = start_x;
                cy_n    = start_y;
                en_n    = 1'b1;
                qx_n    = start_x;
                qy_n    = start_y;
                scan_n  = scan_cnt + SCAN_W'(1);
                state_n = SCAN_CHK;
            end
            SCAN_CHK: begin
                if (!bus.occ_rd_en) begin
                    if (!bus.occ_hit) begin
                        ax_n    = cand_x;
                        ay_n    = cand_y;
                        av_n    = 1'b1;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end else if (scan_cnt == SCAN_MAX) begin
                        full_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = FULL;
                    end else begin
                        cx_n   = step_x;
                        cy_n   = step_y;
                        en_n   = 1'b1;
                        qx_n   = step_x;
                        qy_n   = step_y;
                        scan_n = scan_cnt + SCAN_W'(1);
                    end
                end
            end
            default: ;
        endcase
        if (smp) begin
            cx_n = bus.rand_x;
            cy_n = bus.rand_y;
            if (in_grid(bus.rand_x, bus.rand_y)) begin
                en_n    = 1'b1;
                qx_n    = bus.rand_x;
                qy_n    = bus.rand_y;
                try_n   = base;
                state_n = CHECK;
            end else begin
                try_n   = base + TRY_W'(1);
                state_n = (base + TRY_W'(1) == TRY_MAX) ? SCAN : SAMPLE;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            try_cnt         <= '0;
            scan_cnt        <= '0;
            cand_x          <= '0;
            cand_y          <= '0;
            bus.occ_rd_en   <= 1'b0;
            bus.occ_rd_x    <= '0;
            bus.occ_rd_y    <= '0;
            bus.apple_x     <= INIT_X;
            bus.apple_y     <= INIT_Y;
            bus.apple_valid <= 1'b1;
            bus.busy        <= 1'b0;
            bus.grid_full   <= 1'b0;
        end else begin
            state           <= state_n;
            try_cnt         <= try_n;
            scan_cnt        <= scan_n;
            cand_x          <= cx_n;
            cand_y          <= cy_n;
            bus.occ_rd_en   <= en_n;
            bus.occ_rd_x    <= qx_n;
            bus.occ_rd_y    <= qy_n;
            bus.apple_x     <= ax_n;
            bus.apple_y     <= ay_n;
            bus.apple_valid <= av_n;
            bus.busy        <= busy_n;
            bus.grid_full   <= full_n;
        end
    end
endmodule

// File: tb/tb_apple_placer.sv
// tb_apple_placer: directed vector table plus hand-written multi-cycle sequences for apple_placer
module tb_apple_placer;
    import apple_placer_pkg::*;
    typedef struct {
        int rx;
        int ry;
        int q;
        int ex;
        int ey;
        int lat;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    int qcnt = 0;
    bit occ [GRID_H][GRID_W];
    vec_t vecs [6];
    apple_placer_if bus();
    apple_placer dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // occupancy store model: registered hit one cycle after the query, plus a query counter
    always @(posedge clk) begin
        bus.occ_hit <= bus.occ_rd_en && occ[bus.occ_rd_y][bus.occ_rd_x];
        if (bus.occ_rd_en) qcnt <= qcnt + 1;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic fill(input bit v);
        for (int y = 0; y < GRID_H; y++)
            for (int x = 0; x < GRID_W; x++)
                occ[y][x] = v;
    endtask
    task automatic set_rand(input int x, input int y);
        bus.rand_x = coord_t'(x);
        bus.rand_y = coord_t'(y);
    endtask
    // pulse eat for one cycle; on return the caller is at the negedge of cycle eat+1
    task automatic pulse_eat(input int x, input int y);
        @(negedge clk);
        bus.eat = 1'b1;
        set_rand(x, y);
        @(negedge clk);
        bus.eat = 1'b0;
    endtask
    task automatic wait_valid(inout int n);
        while (!bus.apple_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask
    task automatic check_reset_state(input string tag);
        chk({tag, " apple_x"}, bus.apple_x, 2);
        chk({tag, " apple_y"}, bus.apple_y, 2);
        chk({tag, " apple_valid"}, bus.apple_valid, 1);
        chk({tag, " busy"}, bus.busy, 0);
        chk({tag, " grid_full"}, bus.grid_full, 0);
        chk({tag, " occ_rd_en"}, bus.occ_rd_en, 0);
    endtask
    initial begin
        int n;
        int q0;
        vecs[0] = '{5, 7, 1, 5, 7, 3};
        vecs[1] = '{0, 0, 1, 0, 0, 3};
        vecs[2] = '{29, 19, 1, 29, 19, 3};
        vecs[3] = '{30, 0, 0, 0, 0, 19};
        vecs[4] = '{29, 20, 0, 0, 0, 19};
        vecs[5] = '{31, 31, 0, 0, 0, 19};
        bus.eat = 1'b0;
        set_rand(0, 0);
        fill(1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");
        chk("reset occ_rd_x", bus.occ_rd_x, 0);
        for (int i = 0; i < 6; i++) begin
            pulse_eat(vecs[i].rx, vecs[i].ry);
            n = 1;
            chk($sformatf("v%0d valid_low", i), bus.apple_valid, 0);
            chk($sformatf("v%0d busy", i), bus.busy, 1);
            chk($sformatf("v%0d query_en", i), bus.occ_rd_en, vecs[i].q);
            if (vecs[i].q != 0) begin
                chk($sformatf("v%0d query_x", i), bus.occ_rd_x, vecs[i].rx);
                chk($sformatf("v%0d query_y", i), bus.occ_rd_y, vecs[i].ry);
            end
            wait_valid(n);
            chk($sformatf("v%0d latency", i), n, vecs[i].lat);
            chk($sformatf("v%0d apple_x", i), bus.apple_x, vecs[i].ex);
            chk($sformatf("v%0d apple_y", i), bus.apple_y, vecs[i].ey);
            chk($sformatf("v%0d busy_end", i), bus.busy, 0);
        end
        pulse_eat(31, 3);
        set_rand(4, 25);
        chk("oor query1", bus.occ_rd_en, 0);
        @(negedge clk);
        set_rand(6, 6);
        chk("oor query2", bus.occ_rd_en, 0);
        @(negedge clk);
        chk("oor query3_en", bus.occ_rd_en, 1);
        chk("oor query3_xy", {bus.occ_rd_x, bus.occ_rd_y}, {5'd6, 5'd6});
        n = 3;
        wait_valid(n);
        chk("oor latency", n, 5);
        chk("oor apple", {bus.apple_x, bus.apple_y}, {5'd6, 5'd6});
        fill(1'b1);
        occ[0][1] = 1'b0;
        q0 = qcnt;
        pulse_eat(10, 5);
        n = 1;
        while (!bus.apple_valid && n < 3000) begin
            if (n == 20) set_rand(29, 19);
            if (n == 34) chk("scan q0", {bus.occ_rd_en, bus.occ_rd_x, bus.occ_rd_y}, {1'b1, 5'd0, 5'd0});
            if (n == 36) chk("scan q1", {bus.occ_rd_en, bus.occ_rd_x, bus.occ_rd_y}, {1'b1, 5'd1, 5'd0});
            @(negedge clk);
            n++;
        end
        chk("scan latency", n, 38);
        chk("scan apple", {bus.apple_x, bus.apple_y}, {5'd1, 5'd0});
        chk("scan busy", bus.busy, 0);
        chk("scan queries", qcnt - q0, 18);
        occ[0][1] = 1'b1;
        q0 = qcnt;
        pulse_eat(3, 4);
        n = 1;
        while (!bus.grid_full && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("full latency", n, 1234);
        chk("full valid", bus.apple_valid, 0);
        chk("full busy", bus.busy, 0);
        chk("full queries", qcnt - q0, 616);
        q0 = qcnt;
        pulse_eat(5, 5);
        repeat (5) @(negedge clk);
        chk("full eat busy", bus.busy, 0);
        chk("full eat sticky", bus.grid_full, 1);
        chk("full eat valid", bus.apple_valid, 0);
        chk("full eat queries", qcnt - q0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("full rst");
        fill(1'b0);
        pulse_eat(8, 8);
        bus.eat = 1'b1;
        set_rand(9, 9);
        @(negedge clk);
        bus.eat = 1'b0;
        n = 2;
        wait_valid(n);
        chk("busy eat latency", n, 3);
        chk("busy eat apple", {bus.apple_x, bus.apple_y}, {5'd8, 5'd8});
        q0 = qcnt;
        repeat (6) @(negedge clk);
        chk("busy eat not queued", {bus.busy, bus.apple_valid}, 2'b01);
        chk("busy eat no query", qcnt - q0, 0);
        pulse_eat(31, 31);
        n = 1;
        while (n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("mid scan busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        check_reset_state("async rst");
        @(negedge clk);
        rst = 1'b0;
        q0 = qcnt;
        repeat (25) @(negedge clk);
        check_reset_state("after rst");
        chk("after rst no query", qcnt - q0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
